// File: rtl/restoring_div_16_8.sv
// Sequential 16-by-8 unsigned restoring divider. It produces one quotient bit per
// cycle over 16 cycles and returns a flagged fixed result on a zero divisor.
module restoring_div_16_8 (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] dividend,
    input  logic [7:0]  divisor,
    output logic        busy,
    output logic        done,
    output logic [15:0] quotient,
    output logic [7:0]  remainder,
    output logic        div_by_zero
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      state;
    state_t      next_state;

    // Dividend bits leave work_q at the top while quotient bits enter at the bottom.
    logic [15:0] work_q;
    logic [8:0]  partial_rem;
    logic [7:0]  divisor_reg;
    logic [4:0]  count;

    logic [9:0]  shifted;
    logic [8:0]  diff;
    logic        q_bit;
    logic [8:0]  next_rem;
    logic        last_iter;

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        shifted    = {partial_rem, work_q[15]};
        q_bit      = (shifted >= {2'b00, divisor_reg});
        // When the subtraction is taken, shifted < 2*divisor, so the 9-bit difference is exact.
        diff       = shifted[8:0] - {1'b0, divisor_reg};
        next_rem   = q_bit ? diff : shifted[8:0];
        last_iter  = (count == 5'd15);

        next_state = state;
        case (state)
            IDLE: begin
                if (start) begin
                    next_state = (divisor == 8'd0) ? DONE : CALC;
                end
            end
            CALC: begin
                if (last_iter) begin
                    next_state = DONE;
                end
            end
            DONE: begin
                if (start) begin
                    next_state = (divisor == 8'd0) ? DONE : CALC;
                end else begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign busy = (state == CALC);
    assign done = (state == DONE);

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            work_q      <= 16'd0;
            partial_rem <= 9'd0;
            divisor_reg <= 8'd0;
            count       <= 5'd0;
            quotient    <= 16'd0;
            remainder   <= 8'd0;
            div_by_zero <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (start) begin
                        if (divisor == 8'd0) begin
                            quotient    <= 16'hFFFF;
                            remainder   <= dividend[7:0];
                            div_by_zero <= 1'b1;
                        end else begin
                            work_q      <= dividend;
                            divisor_reg <= divisor;
                            partial_rem <= 9'd0;
                            count       <= 5'd0;
                        end
                    end
                end
                CALC: begin
                    work_q      <= {work_q[14:0], q_bit};
                    partial_rem <= next_rem;
                    count       <= count + 5'd1;
                    // Results are published on the edge entering DONE so they are valid with done.
                    if (last_iter) begin
                        quotient    <= {work_q[14:0], q_bit};
                        remainder   <= next_rem[7:0];
                        div_by_zero <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_restoring_div_16_8.sv
// Self-checking bench for restoring_div_16_8: an arithmetic reference model compared
// on every cycle, plus directed scenarios with hand-computed expectations.
module tb_restoring_div_16_8;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] dividend;
    logic [7:0]  divisor;
    logic        busy;
    logic        done;
    logic [15:0] quotient;
    logic [7:0]  remainder;
    logic        div_by_zero;

    int vectors     = 0;
    int miscompares = 0;

    restoring_div_16_8 dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .dividend    (dividend),
        .divisor     (divisor),
        .busy        (busy),
        .done        (done),
        .quotient    (quotient),
        .remainder   (remainder),
        .div_by_zero (div_by_zero)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a request takes 16 busy cycles, then one done cycle with a/b and a%b.
    bit          m_valid   = 1'b0;
    int          busy_left = 0;
    logic        m_done    = 1'b0;
    logic [15:0] m_q       = '0;
    logic [7:0]  m_r       = '0;
    logic        m_dz      = 1'b0;
    logic [15:0] p_q       = '0;
    logic [7:0]  p_r       = '0;

    always @(posedge clk) begin
        if (reset) begin
            m_valid   = 1'b1;
            busy_left = 0;
            m_done    = 1'b0;
            m_q       = '0;
            m_r       = '0;
            m_dz      = 1'b0;
        end else if (busy_left > 0) begin
            busy_left = busy_left - 1;
            m_done    = (busy_left == 0);
            if (m_done) begin
                m_q  = p_q;
                m_r  = p_r;
                m_dz = 1'b0;
            end
        end else begin
            m_done = 1'b0;
            if (start) begin
                if (divisor == 8'd0) begin
                    m_done = 1'b1;
                    m_q    = 16'hFFFF;
                    m_r    = dividend[7:0];
                    m_dz   = 1'b1;
                end else begin
                    busy_left = 16;
                    p_q       = dividend / {8'd0, divisor};
                    p_r       = 8'(dividend % {8'd0, divisor});
                end
            end
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            check("model_busy", busy, busy_left > 0);
            check("model_done", done, m_done);
            check("model_quotient", quotient, m_q);
            check("model_remainder", remainder, m_r);
            check("model_div_by_zero", div_by_zero, m_dz);
        end
    end

    task automatic do_op(input logic [15:0] a, input logic [7:0] b, input logic [15:0] eq,
                         input logic [7:0] er, input logic edz, input int elat);
        int cyc;
        @(negedge clk);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        @(negedge clk);
        start = 1'b0;
        cyc   = 1;
        check("busy_cycle1", busy, b != 8'd0);
        while (!done && cyc < 40) begin
            dividend = 16'($urandom);
            divisor  = 8'($urandom);
            @(negedge clk);
            cyc++;
        end
        check("latency", cyc, elat);
        check("quotient", quotient, eq);
        check("remainder", remainder, er);
        check("div_by_zero", div_by_zero, edz);
    endtask

    initial begin
        int          ndone;
        int          first_done;
        int          second_done;
        logic [15:0] ra;
        logic [7:0]  rb;

        reset    = 1'b1;
        start    = 1'b0;
        dividend = '0;
        divisor  = '0;
        repeat (2) @(negedge clk);
        check("reset_busy", busy, 0);
        check("reset_done", done, 0);
        check("reset_quotient", quotient, 0);
        check("reset_remainder", remainder, 0);
        check("reset_dbz", div_by_zero, 0);
        reset = 1'b0;

        do_op(16'd20000, 8'd200, 16'd100, 8'd0, 1'b0, 17);
        do_op(16'd65535, 8'd255, 16'd257, 8'd0, 1'b0, 17);
        do_op(16'd1000, 8'd7, 16'd142, 8'd6, 1'b0, 17);
        do_op(16'd5, 8'd10, 16'd0, 8'd5, 1'b0, 17);
        do_op(16'd1234, 8'd0, 16'hFFFF, 8'hD2, 1'b1, 1);

        // A second request arriving mid-calculation must be ignored.
        @(negedge clk);
        start = 1'b1; dividend = 16'd100; divisor = 8'd3;
        @(negedge clk);
        start = 1'b0; ndone = 0; first_done = 0;
        for (int cyc = 1; cyc <= 20; cyc++) begin
            if (done) begin
                ndone++;
                first_done = cyc;
                check("busy_start_q", quotient, 16'd33);
                check("busy_start_r", remainder, 8'd1);
            end
            if (cyc == 5) begin
                start = 1'b1; dividend = 16'd50; divisor = 8'd5;
            end else begin
                start = 1'b0;
            end
            @(negedge clk);
        end
        check("busy_start_ndone", ndone, 1);
        check("busy_start_cycle", first_done, 17);

        // Start held high: a new operation is accepted straight out of DONE.
        start = 1'b1; dividend = 16'd300; divisor = 8'd10;
        @(negedge clk);
        ndone = 0; first_done = 0; second_done = 0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (done) begin
                ndone++;
                if (ndone == 1) first_done = cyc;
                else second_done = cyc;
                check("b2b_q", quotient, 16'd30);
                check("b2b_r", remainder, 8'd0);
            end
            if (cyc == 34) start = 1'b0;
            @(negedge clk);
        end
        check("b2b_ndone", ndone, 2);
        check("b2b_first", first_done, 17);
        check("b2b_second", second_done, 34);

        // Reset during CALC clears everything and suppresses the done pulse.
        start = 1'b1; dividend = 16'd20000; divisor = 8'd200;
        @(negedge clk);
        start = 1'b0;
        for (int cyc = 1; cyc < 8; cyc++) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_q", quotient, 0);
        check("midrst_r", remainder, 0);
        check("midrst_dbz", div_by_zero, 0);
        reset = 1'b0;
        ndone = 0;
        for (int i = 0; i < 20; i++) begin
            if (done) ndone++;
            @(negedge clk);
        end
        check("midrst_no_done", ndone, 0);
        do_op(16'd9, 8'd3, 16'd3, 8'd0, 1'b0, 17);

        for (int i = 0; i < 25; i++) begin
            ra = 16'($urandom);
            rb = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
            if (rb == 8'd0)
                do_op(ra, rb, 16'hFFFF, ra[7:0], 1'b1, 1);
            else
                do_op(ra, rb, ra / {8'd0, rb}, 8'(ra % {8'd0, rb}), 1'b0, 17);
        end

        // Random soak with sporadic starts, zero divisors and resets, checked by the model.
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk);
            start    = ($urandom_range(0, 3) == 0);
            dividend = 16'($urandom);
            divisor  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom);
            reset    = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk);
        start = 1'b0;
        reset = 1'b0;
        repeat (20) @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/restoring_div_16_8.md
RESTORING_DIV_16_8 -- requirements
Module: restoring_div_16_8

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  synchronous, active-high reset.
REQ-004 start  input  1  request pulse; a level held high is sampled every cycle.
REQ-005 dividend  input  16  unsigned dividend, sampled only when start is accepted.
REQ-006 divisor  input  8  unsigned divisor, sampled only when start is accepted.
REQ-007 busy  output  1  high while a division is in progress (CALC state).
REQ-008 done  output  1  single-cycle pulse marking new valid results.
REQ-009 quotient  output  16  unsigned quotient, registered.
REQ-010 remainder  output  8  unsigned remainder, registered.
REQ-011 div_by_zero  output  1  error flag for the last completed operation, registered.

Function
REQ-012 The FSM SHALL have exactly three states: IDLE, CALC, DONE.
REQ-013 Start acceptance: start high in IDLE or DONE accepts a request; start in CALC is ignored, with no effect on state or operands.
REQ-014 On acceptance with divisor != 0, the block SHALL latch the operands, clear the 9-bit partial remainder, load a 5-bit iteration counter with 0 and enter CALC.
REQ-015 CALC iteration, 16 cycles, MSB-first, one quotient bit per cycle:
- shift {partial_rem, dividend_bit};
- if result >= divisor: subtract divisor and set q bit = 1;
- else: keep result and set q bit = 0.
REQ-016 The partial remainder SHALL be 9 bits wide so that the shift never loses a bit; the final remainder is always < divisor and fits in 8 bits.
REQ-017 After the 16th CALC cycle the FSM SHALL enter DONE. Outputs and flags in DONE:
- quotient and remainder load from the working registers;
- div_by_zero loads 0;
- done = 1 for exactly that cycle.
REQ-018 Latency: acceptance edge = cycle 0; done high in cycle 17; results valid from cycle 17 until the next done.
REQ-019 Divide-by-zero: acceptance with divisor == 0 SHALL skip CALC and enter DONE directly, with done high in cycle 1 and:
- quotient = 16'hFFFF;
- remainder = dividend[7:0];
- div_by_zero = 1.
REQ-020 DONE SHALL return to IDLE the next cycle, or go to CALC (or DONE for a zero divisor) if start is high in DONE.
REQ-021 quotient, remainder and div_by_zero SHALL hold their previous values throughout CALC and IDLE, and change only in the DONE cycle.
REQ-022 busy SHALL be 1 exactly in CALC; it is 0 in IDLE and DONE.
REQ-023 Input changes on dividend or divisor during CALC SHALL NOT affect the result in progress.

Reset
REQ-024 reset high at a rising edge SHALL force the following, overriding start and any state, including mid-CALC:
- state = IDLE;
- busy = 0;
- done = 0;
- quotient = 0;
- remainder = 0;
- div_by_zero = 0;
- counter and working registers = 0.
REQ-025 An operation interrupted by reset SHALL NOT produce a done pulse.
REQ-026 The first start after reset deasserts SHALL be accepted normally.

Verification
REQ-027 Normal division: 20000 / 200 -> done in cycle 17, quotient = 100, remainder = 0, div_by_zero = 0; busy high for cycles 1-16.
REQ-028 Maximum operands and remainder check:
- 65535 / 255 -> quotient = 257, remainder = 0;
- 1000 / 7 -> quotient = 142, remainder = 6;
- 5 / 10 -> quotient = 0, remainder = 5.
REQ-029 Zero divisor: 1234 / 0 -> done in cycle 1, quotient = 16'hFFFF, remainder = 8'hD2, div_by_zero = 1; busy never high.
REQ-030 Start while busy: start 100 / 3, then start 50 / 5 in cycle 5 -> second request ignored; one done in cycle 17 with quotient = 33, remainder = 1.
REQ-031 Back-to-back: start held high continuously with 300 / 10 -> done pulses in cycles 17 and 34, both with quotient = 30, remainder = 0.
REQ-032 Reset mid-operation: reset in cycle 8 of 20000 / 200:
- all outputs 0 the next cycle;
- no done pulse;
- a following 9 / 3 -> quotient = 3, remainder = 0, 17 cycles after its start.
